// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: access sizes, FSM states and
// byte-lane select patterns.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane logic: store lane select and replication, alignment check,
// and load lane extraction with sign/zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] read_data,
    output logic [3:0]        sel,
    output logic [DATA_W-1:0] lane_wdata,
    output logic              misaligned,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = read_data[7:0];
        unique case (addr_lo)
            2'd0: byte_v = read_data[7:0];
            2'd1: byte_v = read_data[15:8];
            2'd2: byte_v = read_data[23:16];
            2'd3: byte_v = read_data[31:24];
            default: byte_v = read_data[7:0];
        endcase
        half_v = addr_lo[1] ? read_data[31:16] : read_data[15:0];
    end

    always_comb begin
        sel        = SEL_WORD;
        lane_wdata = store_data;
        misaligned = 1'b0;
        load_data  = read_data;
        case (size)
            SIZE_BYTE: begin
                sel        = SEL_BYTE0 << addr_lo;
                lane_wdata = {(DATA_W/8){store_data[7:0]}};
                load_data  = is_unsigned ? {{(DATA_W-8){1'b0}}, byte_v}
                                         : {{(DATA_W-8){byte_v[7]}}, byte_v};
            end
            SIZE_HALF: begin
                sel        = addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
                lane_wdata = {(DATA_W/16){store_data[15:0]}};
                misaligned = addr_lo[0];
                load_data  = is_unsigned ? {{(DATA_W-16){1'b0}}, half_v}
                                         : {{(DATA_W-16){half_v[15]}}, half_v};
            end
            // Size 11 behaves as a word access.
            default: begin
                sel        = SEL_WORD;
                lane_wdata = store_data;
                misaligned = (addr_lo != 2'b00);
                load_data  = read_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack data-bus transaction per aligned access,
// pipeline stall while busy, and registered MEM/WB writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_en,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_unsigned,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_wdata,
    input  logic              ex_wreg_en,
    input  logic [4:0]        ex_wreg_addr,
    input  logic [DATA_W-1:0] ex_result,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_req,
    output logic              wb_wreg_en,
    output logic [4:0]        wb_wreg_addr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              addr_err,
    output logic [ADDR_W-1:0] addr_err_vaddr
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rt_q;

    logic              wb_en_d;
    logic [4:0]        wb_addr_d;
    logic [DATA_W-1:0] wb_data_d;
    logic              err_d;
    logic [ADDR_W-1:0] vaddr_d;

    logic              is_idle, is_busy, accept;
    logic [1:0]        op_size, op_addr_lo;
    logic              op_uns;
    logic [DATA_W-1:0] op_wdata;
    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata, load_data;
    logic              misaligned;

    assign is_idle = (state_q == StIdle);
    assign is_busy = (state_q == StBusy);

    // The aligner sees the live op while idle and the latched op afterwards.
    assign op_size    = is_idle ? ex_mem_size     : size_q;
    assign op_addr_lo = is_idle ? ex_mem_addr[1:0] : addr_q[1:0];
    assign op_uns     = is_idle ? ex_mem_unsigned : uns_q;
    assign op_wdata   = is_idle ? ex_mem_wdata    : wdata_q;

    mem_lane_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .size        (op_size),
        .addr_lo     (op_addr_lo),
        .is_unsigned (op_uns),
        .store_data  (op_wdata),
        .read_data   (bus_rdata),
        .sel         (lane_sel),
        .lane_wdata  (lane_wdata),
        .misaligned  (misaligned),
        .load_data   (load_data)
    );

    assign accept = is_idle && ex_mem_en && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StBusy;
            StBusy:  if (bus_ack) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_req   = is_busy;
        bus_we    = is_busy && write_q;
        bus_addr  = is_busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus_sel   = is_busy ? lane_sel : 4'b0000;
        bus_wdata = is_busy ? lane_wdata : '0;
        stall_req = !rst && (accept || is_busy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rt_q    <= '0;
        end else if (accept) begin
            addr_q  <= ex_mem_addr;
            size_q  <= ex_mem_size;
            uns_q   <= ex_mem_unsigned;
            write_q <= ex_mem_write;
            wdata_q <= ex_mem_wdata;
            rt_q    <= ex_wreg_addr;
        end
    end

    always_comb begin
        wb_en_d   = 1'b0;
        wb_addr_d = '0;
        wb_data_d = '0;
        err_d     = 1'b0;
        vaddr_d   = addr_err_vaddr;
        case (state_q)
            StIdle: begin
                if (!ex_mem_en) begin
                    wb_en_d   = ex_wreg_en;
                    wb_addr_d = ex_wreg_addr;
                    wb_data_d = ex_result;
                end else if (misaligned) begin
                    err_d   = 1'b1;
                    vaddr_d = ex_mem_addr;
                end
            end
            StBusy: begin
                if (bus_ack && !write_q) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = rt_q;
                    wb_data_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wreg_en     <= 1'b0;
            wb_wreg_addr   <= '0;
            wb_wdata       <= '0;
            addr_err       <= 1'b0;
            addr_err_vaddr <= '0;
        end else begin
            wb_wreg_en     <= wb_en_d;
            wb_wreg_addr   <= wb_addr_d;
            wb_wdata       <= wb_data_d;
            addr_err       <= err_d;
            addr_err_vaddr <= vaddr_d;
        end
    end

endmodule
